vjtag_dr_bank: RTL
==================

// Module: vjtag_dr_bank
// PURPOSE
//  Multi-channel Virtual-JTAG data-register bank. One shared DR_WIDTH shift register serves
//  NUM_CH write channels selected by ir_in, plus BYPASS and a read-only ID register.
//  Each channel has a tck-domain hold register, loaded on Update-DR, and a clk-domain output
//  register, updated through a toggle synchronizer. Sits between sld_virtual_jtag and the
//  pattern-generator core; successor of the single-channel 491-bit JTAG buffer.
// PARAMETERS
//  DR_WIDTH  491           shift/hold/output register width per channel (>=32)
//  NUM_CH    3             write channels; IR codes 1..NUM_CH, NUM_CH <= 2**IR_WIDTH-2
//  IR_WIDTH  3             virtual IR width
//  ID_IR     3'b111        IR code selecting the ID register
//  ID_CODE   32'h0DE0_0002 value captured into the low 32 bits in ID mode (upper bits 0)
// PORTS
//  tck      in   1                 JTAG clock from the virtual JTAG node
//  clk      in   1                 system clock for the output domain
//  aclr     in   1                 async reset, active-high, clears both domains
//  tdi      in   1                 serial data in
//  ir_in    in   IR_WIDTH          current virtual IR
//  v_cdr    in   1                 Capture-DR state; sampled on posedge tck
//  v_sdr    in   1                 Shift-DR state; sampled on posedge tck
//  v_udr    in   1                 Update-DR state; one-tck pulse, sampled on posedge tck
//  tdo      out  1                 serial data out, combinational
//  out_bus  out  NUM_CH*DR_WIDTH   clk-domain channel outputs; ch k at [k*DR_WIDTH +: DR_WIDTH]
//  upd_vld  out  NUM_CH            one-clk pulse per channel when its out_bus slice changes
// BEHAVIOUR
//  Reset: on aclr, shift_reg, hold[k], bypass_reg, tck toggles, sync flops, out_bus and upd_vld
//   go to 0 immediately. Reset mid-shift discards the partial word; no upd_vld after release.
//  Decode: ir_in in 1..NUM_CH -> WRITE(ch=ir_in-1); ir_in==ID_IR -> ID; else BYPASS.
//  tck domain (posedge tck; priority cdr > sdr > udr if several are asserted):
//   v_cdr: WRITE -> shift_reg<=hold[ch] (previous value appears on tdo);
//          ID -> shift_reg<={0,ID_CODE}; BYPASS -> bypass_reg<=0.
//   v_sdr: WRITE/ID -> shift_reg<={tdi,shift_reg[DR_WIDTH-1:1]} (LSB first);
//          BYPASS -> bypass_reg<=tdi.
//   v_udr: WRITE only -> hold[ch]<=shift_reg; tgl[ch]<=~tgl[ch]. ID/BYPASS: no effect.
//  tdo: WRITE/ID -> shift_reg[0]; BYPASS -> bypass_reg. Glitch-free selection is not required.
//  clk domain: per channel, 3-flop chain on tgl[ch]. An edge between flops 2 and 3 gives
//   out_bus slice <= hold[ch] and upd_vld[ch]=1 for exactly one clk.
//   Latency from the v_udr tck edge is 3 clk edges (+<=1 for phase).
//   hold[ch] is stable for >= DR_WIDTH tck after the toggle, so multi-bit sampling is safe.
//   Constrain hold->out_bus as a false/multicycle path.
//  Width: shift_reg is exactly DR_WIDTH; bits beyond DR_WIDTH shifted per scan fall out via tdo.
//   A short scan leaves stale upper bits, which are committed as-is on udr.
//  Repeated updates of the same channel faster than 3 clk are not supported.
//   With DR_WIDTH>=32, one scan always exceeds that.
//  Simultaneous updates on different channels are independent; upd_vld bits may coincide.
// STRUCTURE
//  Shared package vjtag_pkg: IR code constants (IR_BYPASS=0, ID_IR), ID_CODE, ch-decode function.
//  Sub-module toggle_sync (3-flop toggle-to-pulse, async aclr), one instance per channel.
//  Everything else is inline: shift/capture, hold array, tdo mux, output registers.
// TESTING (DR_WIDTH=491, NUM_CH=3, clk 50 MHz, tck 10 MHz)
//  1 Reset: aclr high mid-scan -> out_bus==0, upd_vld==0, tdo==0; release, no pulses for 20 clk.
//  2 Write: IR=1, shift 491 bits with pattern 0xA5 repeated, pulse udr -> upd_vld==3'b001 for one
//    clk within 4 clk of udr; out_bus[490:0] matches pattern; ch1/ch2 slices still 0.
//  3 Readback: IR=2 write X, then IR=2 write Y -> tdo during the 2nd scan streams X LSB first;
//    after udr, ch1 slice == Y.
//  4 ID: IR=7, capture, shift 32 -> tdo yields 0x0DE00002 LSB first; udr leaves out_bus unchanged.
//  5 Bypass: IR=5 -> tdo = tdi delayed one tck (first bit 0); no upd_vld; hold registers unchanged.
//  6 Back-to-back: write ch0 then ch2 with no idle tck -> two distinct upd_vld pulses (bit0 then
//    bit2), each slice holds its own data.

Source files
------------

// File: rtl/vjtag_pkg.sv
// Shared constants and IR decode for the virtual-JTAG data-register bank.
package vjtag_pkg;

    localparam logic [2:0]  IR_BYPASS       = 3'd0;
    localparam logic [2:0]  IR_ID           = 3'b111;
    localparam logic [31:0] ID_CODE_DEFAULT = 32'h0DE0_0002;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_WRITE  = 2'd1,
        MODE_ID     = 2'd2
    } dr_mode_e;

    // IR codes 1..num_ch select a write channel; the ID code wins over everything else.
    function automatic dr_mode_e decode_mode(input logic [7:0] ir,
                                             input logic [7:0] id_ir,
                                             input int         num_ch);
        dr_mode_e mode;
        if (ir == id_ir) begin
            mode = MODE_ID;
        end else if ((ir != {5'd0, IR_BYPASS}) && (int'(ir) <= num_ch)) begin
            mode = MODE_WRITE;
        end else begin
            mode = MODE_BYPASS;
        end
        return mode;
    endfunction

endpackage

// File: rtl/toggle_sync.sv
// Three-flop toggle synchronizer; converts each toggle edge into a one-clk pulse.
module toggle_sync (
    input  logic clk,
    input  logic aclr,
    input  logic tgl,
    output logic pulse
);

    logic [2:0] sync_r;

    // Shift the toggle level through the synchronizer chain.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            sync_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[1:0], tgl};
        end
    end

    // Edge seen between flops 2 and 3; the consumer registers it.
    assign pulse = sync_r[1] ^ sync_r[2];

endmodule

// File: rtl/vjtag_dr_bank.sv
// Multi-channel virtual-JTAG DR bank: shared shift register, per-channel hold
// registers in the tck domain and clk-domain output registers.
module vjtag_dr_bank
    import vjtag_pkg::*;
#(
    parameter int                  DR_WIDTH = 491,
    parameter int                  NUM_CH   = 3,
    parameter int                  IR_WIDTH = 3,
    parameter logic [IR_WIDTH-1:0] ID_IR    = IR_ID,
    parameter logic [31:0]         ID_CODE  = ID_CODE_DEFAULT
) (
    input  logic                         tck,
    input  logic                         clk,
    input  logic                         aclr,
    input  logic                         tdi,
    input  logic [IR_WIDTH-1:0]          ir_in,
    input  logic                         v_cdr,
    input  logic                         v_sdr,
    input  logic                         v_udr,
    output logic                         tdo,
    output logic [NUM_CH*DR_WIDTH-1:0]   out_bus,
    output logic [NUM_CH-1:0]            upd_vld
);

    dr_mode_e              mode_s;
    logic [NUM_CH-1:0]     sel_s;
    logic [DR_WIDTH-1:0]   hold_sel_s;
    logic [DR_WIDTH-1:0]   shift_r;
    logic                  bypass_r;
    logic [DR_WIDTH-1:0]   hold_r [NUM_CH];
    logic [NUM_CH-1:0]     tgl_r;
    logic [NUM_CH-1:0]     pulse_s;
    logic [NUM_CH*DR_WIDTH-1:0] out_bus_r;
    logic [NUM_CH-1:0]     upd_vld_r;

    assign mode_s = decode_mode(8'(ir_in), 8'(ID_IR), NUM_CH);

    // Channel select and the hold word that Capture-DR loads back for readback.
    always_comb begin
        sel_s      = '0;
        hold_sel_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if ((mode_s == MODE_WRITE) && (ir_in == IR_WIDTH'(k + 1))) begin
                sel_s[k]   = 1'b1;
                hold_sel_s = hold_r[k];
            end else begin
                sel_s[k]   = 1'b0;
            end
        end
    end

    // tck domain: capture > shift > update; shift is LSB first.
    always_ff @(posedge tck or posedge aclr) begin
        if (aclr) begin
            shift_r  <= '0;
            bypass_r <= 1'b0;
            tgl_r    <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                hold_r[k] <= '0;
            end
        end else if (v_cdr) begin
            case (mode_s)
                MODE_WRITE:  shift_r  <= hold_sel_s;
                MODE_ID:     shift_r  <= DR_WIDTH'(ID_CODE);
                MODE_BYPASS: bypass_r <= 1'b0;
                default:     bypass_r <= 1'b0;
            endcase
        end else if (v_sdr) begin
            case (mode_s)
                MODE_WRITE:  shift_r  <= {tdi, shift_r[DR_WIDTH-1:1]};
                MODE_ID:     shift_r  <= {tdi, shift_r[DR_WIDTH-1:1]};
                MODE_BYPASS: bypass_r <= tdi;
                default:     bypass_r <= tdi;
            endcase
        end else if (v_udr) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (sel_s[k]) begin
                    hold_r[k] <= shift_r;
                    tgl_r[k]  <= ~tgl_r[k];
                end
            end
        end
    end

    assign tdo = (mode_s == MODE_BYPASS) ? bypass_r : shift_r[0];

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_sync
            toggle_sync u_sync (
                .clk   (clk),
                .aclr  (aclr),
                .tgl   (tgl_r[g]),
                .pulse (pulse_s[g])
            );
        end
    endgenerate

    // clk domain: hold is quiet for a full scan after its toggle, so a wide sample is safe.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            out_bus_r <= '0;
            upd_vld_r <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (pulse_s[k]) begin
                    out_bus_r[k*DR_WIDTH +: DR_WIDTH] <= hold_r[k];
                end
            end
            upd_vld_r <= pulse_s;
        end
    end

    assign out_bus = out_bus_r;
    assign upd_vld = upd_vld_r;

endmodule
